// File: rtl/matrix_add_stream_if.sv
// ============================================================================
// Module : matrix_add_stream_if
// Brief  : Operand/result valid-ready stream bundle for matrix_add_stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface matrix_add_stream_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_sum;
  logic [LANES-1:0]        out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/matrix_add_stream.sv
// ============================================================================
// Module : matrix_add_stream
// Brief  : Two-stage pipelined lane-wise adder, signed/unsigned, wrap/saturate.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module matrix_add_stream #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int CNT_W  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  matrix_add_stream_if.slave    bus,
  input  wire logic             clr,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int RAW_W = DATA_W + 1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic                    s1_valid_q, s1_valid_d;
  logic [LANES*RAW_W-1:0]  s1_raw_q,   s1_raw_d;
  logic [1:0]              s1_mode_q,  s1_mode_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_sum_q,  out_sum_d;
  logic [LANES-1:0]        out_ovf_q,  out_ovf_d;
  logic                    sticky_q,   sticky_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;

  logic                    w_s2_adv;
  logic                    w_s1_adv;
  logic                    w_out_hs;
  logic [LANES*RAW_W-1:0]  w_raw;
  logic [LANES*DATA_W-1:0] w_lane_sum;
  logic [LANES-1:0]        w_lane_ovf;

  assign w_s2_adv = !out_valid_q || bus.out_ready;
  assign w_s1_adv = !s1_valid_q || w_s2_adv;
  assign w_out_hs = out_valid_q && bus.out_ready;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DATA_W-1:0] w_a, w_b;
      logic              w_ext_a, w_ext_b;
      logic [RAW_W-1:0]  w_r;
      logic              w_ovf;
      logic [DATA_W-1:0] w_sat;

      assign w_a     = bus.in_a[i*DATA_W +: DATA_W];
      assign w_b     = bus.in_b[i*DATA_W +: DATA_W];
      // Sign-extend in signed mode so bit DATA_W is the true sign of the sum.
      assign w_ext_a = bus.in_mode[0] & w_a[DATA_W-1];
      assign w_ext_b = bus.in_mode[0] & w_b[DATA_W-1];
      assign w_raw[i*RAW_W +: RAW_W] = {w_ext_a, w_a} + {w_ext_b, w_b};

      assign w_r   = s1_raw_q[i*RAW_W +: RAW_W];
      assign w_ovf = s1_mode_q[0] ? (w_r[DATA_W] ^ w_r[DATA_W-1]) : w_r[DATA_W];
      assign w_sat = !s1_mode_q[0] ? {DATA_W{1'b1}} :
                     w_r[DATA_W]   ? {1'b1, {(DATA_W-1){1'b0}}} :
                                     {1'b0, {(DATA_W-1){1'b1}}};
      assign w_lane_ovf[i] = w_ovf;
      assign w_lane_sum[i*DATA_W +: DATA_W] = (w_ovf && s1_mode_q[1]) ? w_sat
                                                                       : w_r[DATA_W-1:0];
    end
  endgenerate

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_raw_d    = s1_raw_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    if (w_s1_adv) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_raw_d  = w_raw;
        s1_mode_d = bus.in_mode;
      end
    end

    if (w_s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_sum_d = w_lane_sum;
        out_ovf_d = w_lane_ovf;
      end
    end

    // A clear wins over a coincident handshake.
    if (clr) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (w_out_hs) begin
      sticky_d = sticky_q | (|out_ovf_q);
      cnt_d    = cnt_q + c_cnt_one;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_raw_q    <= '0;
      s1_mode_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= '0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_raw_q    <= s1_raw_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign ovf_sticky    = sticky_q;
  assign beat_cnt      = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_matrix_add_stream.sv
// ============================================================================
// Module : tb_matrix_add_stream
// Brief  : Self-checking bench for matrix_add_stream against an arithmetic model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_add_stream;
  localparam int DW = 16;
  localparam int LN = 4;
  localparam int CW = 4;
  localparam int W  = DW * LN;

  typedef struct packed {
    logic [W-1:0]  s;
    logic [LN-1:0] o;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          ovf_sticky;
  logic [CW-1:0] beat_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic exp_sticky = 1'b0;

  matrix_add_stream_if #(.DATA_W(DW), .LANES(LN)) bus ();

  matrix_add_stream #(.DATA_W(DW), .LANES(LN), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .clr        (clr),
    .ovf_sticky (ovf_sticky),
    .beat_cnt   (beat_cnt)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic straight from the signed/unsigned wrap/saturate rules.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] mode,
                                output logic [W-1:0] s, output logic [LN-1:0] o);
    longint full, half, ua, ub, r;
    logic [63:0] rv;
    full = longint'(1) << DW;
    half = longint'(1) << (DW - 1);
    s = '0;
    o = '0;
    for (int i = 0; i < LN; i++) begin
      ua = longint'(a[i*DW +: DW]);
      ub = longint'(b[i*DW +: DW]);
      if (!mode[0]) begin
        r = ua + ub;
        o[i] = (r >= full);
        if (o[i]) r = mode[1] ? full - 1 : r - full;
      end else begin
        if (ua >= half) ua = ua - full;
        if (ub >= half) ub = ub - full;
        r = ua + ub;
        o[i] = (r >= half) || (r < -half);
        if (o[i] && mode[1]) r = (r > 0) ? half - 1 : -half;
      end
      rv = r;
      s[i*DW +: DW] = rv[DW-1:0];
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_mode = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_sum !== '0) begin bad++; $display("FAIL reset_out_sum got=%h want=0", bus.out_sum); end
    total++; if (bus.out_ovf !== '0) begin bad++; $display("FAIL reset_out_ovf got=%b want=0", bus.out_ovf); end
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", ovf_sticky); end
    total++; if (beat_cnt !== '0) begin bad++; $display("FAIL reset_beat_cnt got=%0d want=0", beat_cnt); end
    exp_cnt = 0; exp_sticky = 1'b0;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [1:0] mode, input logic [W-1:0] es, input logic [LN-1:0] eo);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_mode = mode; bus.out_ready = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%b want=1", name, bus.in_ready); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid got=%b want=0", name, bus.out_valid); end
    @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL %s_latency got=%b want=1", name, bus.out_valid); end
    total++; if (bus.out_sum !== es) begin bad++; $display("FAIL %s_sum got=%h want=%h", name, bus.out_sum, es); end
    total++; if (bus.out_ovf !== eo) begin bad++; $display("FAIL %s_ovf got=%b want=%b", name, bus.out_ovf, eo); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    exp_sticky = exp_sticky | (|eo);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL %s_drained got=%b want=0", name, bus.out_valid); end
    total++; if (beat_cnt !== CW'(exp_cnt)) begin bad++; $display("FAIL %s_cnt got=%0d want=%0d", name, beat_cnt, exp_cnt); end
    total++; if (ovf_sticky !== exp_sticky) begin bad++; $display("FAIL %s_sticky got=%b want=%b", name, ovf_sticky, exp_sticky); end
  endtask

  task automatic test_back_pressure();
    logic [W-1:0]  ba [6];
    logic [W-1:0]  bb [6];
    logic [1:0]    bm [6];
    logic [W-1:0]  es [6];
    logic [LN-1:0] eo [6];
    int acc, got, gaps;
    for (int k = 0; k < 6; k++) begin
      ba[k] = {$urandom, $urandom};
      bb[k] = {$urandom, $urandom};
      bm[k] = 2'($urandom_range(0, 3));
      model(ba[k], bb[k], bm[k], es[k], eo[k]);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    #1;
    total++; if (beat_cnt !== '0 || ovf_sticky !== 1'b0) begin bad++; $display("FAIL bp_clr got=%0d/%b want=0/0", beat_cnt, ovf_sticky); end
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = ba[acc]; bus.in_b = bb[acc]; bus.in_mode = bm[acc];
      #1;
      if (bus.in_ready) acc++;
    end
    total++; if (acc !== 2) begin bad++; $display("FAIL bp_accepted got=%0d want=2", acc); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
    total++; if (bus.out_sum !== es[0] || bus.out_ovf !== eo[0]) begin bad++; $display("FAIL bp_hold got=%h/%b want=%h/%b", bus.out_sum, bus.out_ovf, es[0], eo[0]); end
    got = 0; gaps = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = (acc < 6);
      if (acc < 6) begin bus.in_a = ba[acc]; bus.in_b = bb[acc]; bus.in_mode = bm[acc]; end
      #1;
      if (bus.out_valid) begin
        total++; if (bus.out_sum !== es[got] || bus.out_ovf !== eo[got]) begin bad++; $display("FAIL bp_order beat=%0d got=%h/%b want=%h/%b", got, bus.out_sum, bus.out_ovf, es[got], eo[got]); end
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        exp_sticky = exp_sticky | (|eo[got]);
        got++;
      end else if (got > 0) begin
        gaps++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
    end
    total++; if (got !== 6 || gaps !== 0) begin bad++; $display("FAIL bp_stream got=%0d beats %0d gaps want=6 beats 0 gaps", got, gaps); end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    total++; if (beat_cnt !== CW'(6)) begin bad++; $display("FAIL bp_cnt got=%0d want=6", beat_cnt); end
  endtask

  task automatic test_clr_wrap();
    int n, sent, got;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = W'(16'hFFFF); bus.in_b = W'(16'h0001); bus.in_mode = 2'b00;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    #1;
    while (!bus.out_valid && n < 10) begin @(negedge clk); #1; n++; end
    total++; if (bus.out_valid !== 1'b1 || bus.out_ovf !== 4'b0001) begin bad++; $display("FAIL clr_setup got=%b/%b want=1/0001", bus.out_valid, bus.out_ovf); end
    @(negedge clk);
    clr = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    clr = 1'b0; bus.out_ready = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    #1;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL clr_sticky got=%b want=0", ovf_sticky); end
    total++; if (beat_cnt !== '0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", beat_cnt); end
    sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 16; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid = (sent < 16);
      bus.in_a = W'($urandom); bus.in_b = '0; bus.in_mode = 2'b00;
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid) got++;
      if (got == 15) begin
        total++; if (beat_cnt !== CW'(14) && beat_cnt !== CW'(15)) begin bad++; $display("FAIL wrap_mid got=%0d want=14..15", beat_cnt); end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    total++; if (got !== 16 || beat_cnt !== '0) begin bad++; $display("FAIL wrap_cnt got=%0d beats cnt=%0d want=16 beats cnt=0", got, beat_cnt); end
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL wrap_sticky got=%b want=0", ovf_sticky); end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0]  a, b, es;
    logic [LN-1:0] eo;
    int stale;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = {$urandom, $urandom}; bus.in_b = {$urandom, $urandom}; bus.in_mode = 2'b01;
    @(negedge clk);
    bus.in_a = {$urandom, $urandom};
    @(negedge clk);
    bus.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.out_valid); end
    total++; if (beat_cnt !== '0 || ovf_sticky !== 1'b0) begin bad++; $display("FAIL rst_mid_status got=%0d/%b want=0/0", beat_cnt, ovf_sticky); end
    stale = 0;
    repeat (4) begin @(negedge clk); #1; if (bus.out_valid) stale++; end
    total++; if (stale !== 0) begin bad++; $display("FAIL rst_mid_stale got=%0d want=0", stale); end
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    model(a, b, 2'b11, es, eo);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_mode = 2'b11; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b1 || bus.out_sum !== es || bus.out_ovf !== eo) begin bad++; $display("FAIL rst_mid_after got=%b/%h/%b want=1/%h/%b", bus.out_valid, bus.out_sum, bus.out_ovf, es, eo); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_cnt = 1; exp_sticky = |eo;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    logic hs_out, do_clr;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_a      = {$urandom, $urandom};
      bus.in_b      = {$urandom, $urandom};
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 9) < 7);
      do_clr        = ($urandom_range(0, 31) == 0);
      clr           = do_clr;
      #1;
      total++; if (beat_cnt !== CW'(exp_cnt) || ovf_sticky !== exp_sticky) begin bad++; $display("FAIL rand_status cyc=%0d got=%0d/%b want=%0d/%b", c, beat_cnt, ovf_sticky, exp_cnt, exp_sticky); end
      hs_out = bus.out_valid && bus.out_ready;
      if (bus.out_valid) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_spurious cyc=%0d got=valid want=idle", c);
        end else if (bus.out_sum !== q[0].s || bus.out_ovf !== q[0].o) begin
          bad++; $display("FAIL rand_beat cyc=%0d got=%h/%b want=%h/%b", c, bus.out_sum, bus.out_ovf, q[0].s, q[0].o);
        end
      end
      if (do_clr) begin
        exp_cnt = 0; exp_sticky = 1'b0;
      end else if (hs_out && q.size() != 0) begin
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        exp_sticky = exp_sticky | (|q[0].o);
      end
      if (hs_out && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) begin
        model(bus.in_a, bus.in_b, bus.in_mode, e.s, e.o);
        q.push_back(e);
      end
    end
    clr = 1'b0;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      #1;
      if (bus.out_valid) begin
        total++; if (bus.out_sum !== q[0].s || bus.out_ovf !== q[0].o) begin bad++; $display("FAIL rand_drain got=%h/%b want=%h/%b", bus.out_sum, bus.out_ovf, q[0].s, q[0].o); end
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        exp_sticky = exp_sticky | (|q[0].o);
        void'(q.pop_front());
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    #1;
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_leftover got=%0d want=0", q.size()); end
    total++; if (beat_cnt !== CW'(exp_cnt) || ovf_sticky !== exp_sticky) begin bad++; $display("FAIL rand_final got=%0d/%b want=%0d/%b", beat_cnt, ovf_sticky, exp_cnt, exp_sticky); end
  endtask

  initial begin
    test_reset();
    test_directed("uwrap", {16'hFFFF, 16'h0003, 16'h0002, 16'h0001}, {16'h0001, 16'h0005, 16'h7FFF, 16'h0001},
                  2'b00, {16'h0000, 16'h0008, 16'h8001, 16'h0002}, 4'b1000);
    test_directed("usat", {16'hFFFF, 16'h0003, 16'h0002, 16'h0001}, {16'h0001, 16'h0005, 16'h7FFF, 16'h0001},
                  2'b10, {16'hFFFF, 16'h0008, 16'h8001, 16'h0002}, 4'b1000);
    test_directed("ssat", {16'hFFFF, 16'h0003, 16'h0002, 16'h0001}, {16'h0001, 16'h0005, 16'h7FFF, 16'h0001},
                  2'b11, {16'h0000, 16'h0008, 16'h7FFF, 16'h0002}, 4'b0010);
    test_directed("sneg_sat", {48'h0, 16'h8000}, {48'h0, 16'hFFFF}, 2'b11, {48'h0, 16'h8000}, 4'b0001);
    test_directed("sneg_wrap", {48'h0, 16'h8000}, {48'h0, 16'hFFFF}, 2'b01, {48'h0, 16'h7FFF}, 4'b0001);
    test_back_pressure();
    test_clr_wrap();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
